// File: rtl/mem_access_stage.sv
// Memory pipeline stage: issues load/store on a req/ack bus, aligns load data,
// and produces the write-back value. Flags misaligned accesses and ack timeouts.
module mem_access_stage #(
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [5:0]  instr_id_in,
  input  logic [31:0] mem_addr_in,
  input  logic [31:0] rs2_value_in,
  input  logic [31:0] exec_output_in,
  input  logic [4:0]  rd_addr_in,
  input  logic        rd_valid_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_out,
  output logic        wb_valid,
  output logic [4:0]  wb_rd_addr,
  output logic [31:0] wb_data,
  output logic        misaligned_exc,
  output logic        bus_err,
  output logic [31:0] exc_addr
);

  localparam logic [5:0] INSTR_LB  = 6'd10;
  localparam logic [5:0] INSTR_LH  = 6'd11;
  localparam logic [5:0] INSTR_LW  = 6'd12;
  localparam logic [5:0] INSTR_LBU = 6'd13;
  localparam logic [5:0] INSTR_LHU = 6'd14;
  localparam logic [5:0] INSTR_SB  = 6'd15;
  localparam logic [5:0] INSTR_SH  = 6'd16;
  localparam logic [5:0] INSTR_SW  = 6'd17;

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [5:0]       r_op;
  logic [31:0]      r_addr;
  logic [4:0]       r_rd;
  logic             r_rdv;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_half;
  logic        w_is_word;
  logic        w_misaligned;
  logic        w_go;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  assign w_is_load  = (instr_id_in >= INSTR_LB) && (instr_id_in <= INSTR_LHU);
  assign w_is_store = (instr_id_in >= INSTR_SB) && (instr_id_in <= INSTR_SW);
  assign w_is_half  = (instr_id_in == INSTR_LH) || (instr_id_in == INSTR_LHU) ||
                      (instr_id_in == INSTR_SH);
  assign w_is_word  = (instr_id_in == INSTR_LW) || (instr_id_in == INSTR_SW);
  assign w_misaligned = (w_is_half && mem_addr_in[0]) ||
                        (w_is_word && (mem_addr_in[1:0] != 2'b00));
  assign w_go = in_valid && (w_is_load || w_is_store) && !w_misaligned;

  // Stall is combinational so upstream holds the slot in the issue cycle itself.
  assign stall_out = (r_state == S_IDLE) ? w_go : !dmem_ack;

  always_comb begin
    w_wdata = rs2_value_in;
    w_wstrb = 4'b0000;
    if (instr_id_in == INSTR_SB) begin
      w_wdata = {4{rs2_value_in[7:0]}};
      w_wstrb = 4'b0001 << mem_addr_in[1:0];
    end else if (instr_id_in == INSTR_SH) begin
      w_wdata = {2{rs2_value_in[15:0]}};
      w_wstrb = mem_addr_in[1] ? 4'b1100 : 4'b0011;
    end else if (instr_id_in == INSTR_SW) begin
      w_wstrb = 4'b1111;
    end
  end

  always_comb begin
    w_byte = 8'h00;
    case (r_addr[1:0])
      2'b00:   w_byte = dmem_rdata[7:0];
      2'b01:   w_byte = dmem_rdata[15:8];
      2'b10:   w_byte = dmem_rdata[23:16];
      default: w_byte = dmem_rdata[31:24];
    endcase
    w_half = r_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    w_load_data = dmem_rdata;
    case (r_op)
      INSTR_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
      INSTR_LBU: w_load_data = {24'h0, w_byte};
      INSTR_LH:  w_load_data = {{16{w_half[15]}}, w_half};
      INSTR_LHU: w_load_data = {16'h0, w_half};
      default:   w_load_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_op           <= '0;
      r_addr         <= '0;
      r_rd           <= '0;
      r_rdv          <= 1'b0;
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      dmem_wstrb     <= '0;
      wb_valid       <= 1'b0;
      wb_rd_addr     <= '0;
      wb_data        <= '0;
      misaligned_exc <= 1'b0;
      bus_err        <= 1'b0;
      exc_addr       <= '0;
    end else begin
      wb_valid       <= 1'b0;
      misaligned_exc <= 1'b0;
      bus_err        <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (!(w_is_load || w_is_store)) begin
              wb_valid   <= rd_valid_in;
              wb_data    <= exec_output_in;
              wb_rd_addr <= rd_addr_in;
            end else if (w_misaligned) begin
              misaligned_exc <= 1'b1;
              exc_addr       <= mem_addr_in;
            end else begin
              r_state    <= S_BUSY;
              r_cnt      <= '0;
              r_op       <= instr_id_in;
              r_addr     <= mem_addr_in;
              r_rd       <= rd_addr_in;
              r_rdv      <= rd_valid_in;
              dmem_req   <= 1'b1;
              dmem_we    <= w_is_store;
              dmem_addr  <= {mem_addr_in[31:2], 2'b00};
              dmem_wdata <= w_wdata;
              dmem_wstrb <= w_wstrb;
            end
          end
        end
        S_BUSY: begin
          // An ack in the final countdown cycle still completes the access.
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            r_state  <= S_IDLE;
            if (!dmem_we) begin
              wb_valid   <= r_rdv;
              wb_data    <= w_load_data;
              wb_rd_addr <= r_rd;
            end
          end else if (r_cnt == LP_CNT_LAST) begin
            bus_err  <= 1'b1;
            exc_addr <= r_addr;
            dmem_req <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
